// File: rtl/arb_pkg.sv
// arb_pkg: shared encodings for the IF/MEM memory port arbiter
package arb_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MEM = 1'b1;
  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;
  typedef struct packed {
    logic owner;
    logic rw;
    logic size;
    logic err;
  } req_attr_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared port
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          mem_req;
  logic          mem_rw;
  logic          mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_err;
  logic          mem_stall;
  logic          ram_en;
  logic          ram_rw;
  logic          ram_size;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_size, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_err, mem_stall,
    output ram_en, ram_rw, ram_size, ram_addr, ram_wdata
  );
  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_size, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_err, mem_stall,
    input  ram_en, ram_rw, ram_size, ram_addr, ram_wdata
  );
endinterface

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable down-counter with zero flag for memory access latency
module arb_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int LAT = 1,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(LAT) + 1;
  localparam int WW = $clog2(STARVE_MAX + 2);
  logic [1:0]    state;
  req_attr_t     attr;
  logic [WW-1:0] wait_cnt;
  logic          force_if;
  logic          grant_mem;
  logic          grant_if;
  logic          misalign;
  logic          cnt_zero;
  always_comb begin
    force_if = STARVE_MAX != 0 && wait_cnt == WW'(STARVE_MAX);
    grant_mem = state == ST_IDLE && bus.mem_req && !(bus.if_req && force_if);
    grant_if = state == ST_IDLE && bus.if_req && !grant_mem;
    misalign = bus.mem_size == SZ_WORD && bus.mem_addr[1:0] != 2'b00;
  end
  // Done/err are Moore outputs of RESP so an async reset clears them immediately
  assign bus.ram_en = state == ST_ACCESS;
  assign bus.if_done = state == ST_RESP && attr.owner == OWN_IF;
  assign bus.mem_done = state == ST_RESP && attr.owner == OWN_MEM;
  assign bus.mem_err = bus.mem_done && attr.err;
  assign bus.if_stall = bus.if_req && !bus.if_done;
  assign bus.mem_stall = bus.mem_req && !bus.mem_done;
  arb_lat_counter #(.W(CW)) u_lat (
    .clk     (clk),
    .reset   (reset),
    .load    (grant_if || (grant_mem && !misalign)),
    .load_val(CW'(LAT - 1)),
    .dec     (state == ST_ACCESS && !cnt_zero),
    .zero    (cnt_zero)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      attr <= '0;
      wait_cnt <= '0;
      bus.ram_addr <= '0;
      bus.ram_rw <= 1'b0;
      bus.ram_size <= 1'b0;
      bus.ram_wdata <= '0;
      bus.if_rdata <= '0;
      bus.mem_rdata <= '0;
    end else begin
      if (grant_if) wait_cnt <= '0;
      else if (grant_mem && bus.if_req && wait_cnt != WW'(STARVE_MAX)) wait_cnt <= wait_cnt + 1'b1;
      if (grant_mem || grant_if) begin
        state <= grant_mem && misalign ? ST_RESP : ST_ACCESS;
        attr <= '{owner: grant_mem, rw: grant_mem && bus.mem_rw,
                  size: grant_mem ? bus.mem_size : SZ_WORD, err: grant_mem && misalign};
        bus.ram_addr <= grant_mem ? bus.mem_addr : bus.if_addr;
        bus.ram_rw <= grant_mem && bus.mem_rw;
        bus.ram_size <= grant_mem ? bus.mem_size : SZ_WORD;
        if (grant_mem) bus.ram_wdata <= bus.mem_wdata;
      end else if (state == ST_ACCESS && cnt_zero) begin
        state <= ST_RESP;
        if (attr.owner == OWN_IF) bus.if_rdata <= bus.ram_rdata;
        else if (!attr.rw) bus.mem_rdata <= bus.ram_rdata;
      end else if (state == ST_RESP) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule
